// File: rtl/adventure_autoplayer_if.sv
// Game-side connection of the autoplayer: the player drives start/direction,
// the game answers with room, sword and result.
interface adventure_autoplayer_if;
  logic       start;
  logic [1:0] direction;
  logic [2:0] room;
  logic       sword;
  logic       result;

  modport master (output start, direction, input room, sword, result);
  modport slave  (input start, direction, output room, sword, result);
endinterface

// File: rtl/adventure_autoplayer.sv
// Scripted player for the adventure game: walks to the sword stash (unless told
// to skip it), then to the dragon den, and reports win/lose/fault plus moves.
module adventure_autoplayer #(
  parameter int unsigned HOLD_CYCLES  = 7,
  parameter int unsigned START_CYCLES = 10,
  parameter int unsigned TIMEOUT      = 63,
  parameter int unsigned MAX_MOVES    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          go_i,
  input  logic                          skip_sword_i,
  adventure_autoplayer_if.master        game,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          won_o,
  output logic                          lost_o,
  output logic                          fault_o,
  output logic [7:0]                    move_count_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START_WAIT, S_DECIDE, S_DRIVE, S_WAIT_MOVE, S_FINISH
  } state_e;

  localparam logic [2:0] ROOM_TUNNEL = 3'b001;
  localparam logic [2:0] ROOM_RIVER  = 3'b010;
  localparam logic [2:0] ROOM_DEN    = 3'b100;
  localparam logic [2:0] ROOM_VAULT  = 3'b101;
  localparam logic [2:0] ROOM_GRAVE  = 3'b110;
  localparam logic [2:0] ROOM_BAD    = 3'b111;

  localparam logic [1:0] DIR_N = 2'b00;
  localparam logic [1:0] DIR_E = 2'b01;
  localparam logic [1:0] DIR_S = 2'b10;
  localparam logic [1:0] DIR_W = 2'b11;

  localparam logic [7:0] START_LAST   = 8'(START_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] MOVES_LIMIT  = 8'(MAX_MOVES);

  state_e     state_q;
  logic       mode_q;
  logic [2:0] prev_room_q;
  logic [7:0] cnt_q;
  logic       start_q;
  logic [1:0] dir_q;
  logic       busy_q, done_q, won_q, lost_q, fault_q;
  logic [7:0] move_count_q;

  logic [1:0] dir_d;
  logic [7:0] move_count_d;
  logic       goal_stash;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    goal_stash   = !mode_q && !game.sword;
    dir_d        = DIR_E;
    case (game.room)
      ROOM_TUNNEL: dir_d = DIR_S;
      ROOM_RIVER:  dir_d = goal_stash ? DIR_W : DIR_E;
      default:     dir_d = DIR_E;
    endcase
    move_count_d = (move_count_q == 8'hFF) ? move_count_q : move_count_q + 8'd1;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      prev_room_q  <= 3'b000;
      cnt_q        <= 8'd0;
      start_q      <= 1'b0;
      dir_q        <= DIR_N;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      won_q        <= 1'b0;
      lost_q       <= 1'b0;
      fault_q      <= 1'b0;
      move_count_q <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go_i) begin
            mode_q       <= skip_sword_i;
            move_count_q <= 8'd0;
            won_q        <= 1'b0;
            lost_q       <= 1'b0;
            fault_q      <= 1'b0;
            cnt_q        <= 8'd0;
            start_q      <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_START_WAIT;
          end
        end

        S_START_WAIT: begin
          if (cnt_q == START_LAST) begin
            cnt_q   <= 8'd0;
            state_q <= S_DECIDE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        S_DECIDE: begin
          prev_room_q <= game.room;
          cnt_q       <= 8'd0;
          case (game.room)
            // The den moves the player on its own; keep the current direction.
            ROOM_DEN: state_q <= S_WAIT_MOVE;
            ROOM_VAULT: begin
              won_q   <= game.result;
              fault_q <= !game.result;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end
            ROOM_GRAVE: begin
              lost_q  <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end
            ROOM_BAD: begin
              fault_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end
            default: begin
              dir_q   <= dir_d;
              state_q <= S_DRIVE;
            end
          endcase
        end

        S_DRIVE: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q   <= 8'd0;
            state_q <= S_WAIT_MOVE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        S_WAIT_MOVE: begin
          if (game.room != prev_room_q) begin
            move_count_q <= move_count_d;
            cnt_q        <= 8'd0;
            if (move_count_d == MOVES_LIMIT) begin
              fault_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              state_q <= S_DECIDE;
            end
          end else if (cnt_q == TIMEOUT_LAST) begin
            fault_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        S_FINISH: ;  // Results hold until reset.

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign game.start     = start_q;
  assign game.direction = dir_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign won_o          = won_q;
  assign lost_o         = lost_q;
  assign fault_o        = fault_q;
  assign move_count_o   = move_count_q;

endmodule

// File: tb/tb_adventure_autoplayer.sv
// Directed bench for adventure_autoplayer against a small behavioural game model.
module tb_adventure_autoplayer;
  localparam int HOLD     = 7;
  localparam int STARTC   = 10;
  localparam int TMO      = 63;
  localparam int MAXM     = 16;
  localparam int MOVE_K   = 10;  // game needs a legal direction held this long
  localparam int DEN_K    = 5;   // clocks the den takes before moving the player

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic       skip_sword = 1'b0;
  logic       busy, done, won, lost, fault;
  logic [7:0] move_count;

  adventure_autoplayer_if gif ();

  adventure_autoplayer #(
    .HOLD_CYCLES(HOLD), .START_CYCLES(STARTC), .TIMEOUT(TMO), .MAX_MOVES(MAXM)
  ) dut (
    .clk(clk), .reset(reset), .go_i(go), .skip_sword_i(skip_sword), .game(gif.master),
    .busy_o(busy), .done_o(done), .won_o(won), .lost_o(lost), .fault_o(fault),
    .move_count_o(move_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Game model. Modes: 0 normal, 1 frozen once in the tunnel,
  // 2 tunnel/river oscillation, 3 stuck in the vault with result=0.
  int         model_mode = 0;
  int         stable = 0;
  int         dwell  = 0;
  logic [1:0] last_dir = 2'b00;
  logic [2:0] nxt;
  logic [2:0] q_rooms[$];
  logic [1:0] q_dirs[$];

  always @(negedge clk) begin
    if (gif.start !== 1'b1) begin
      gif.room   = (model_mode == 3) ? 3'b101 : 3'b000;
      gif.sword  = 1'b0;
      gif.result = 1'b0;
      stable     = 0;
      dwell      = 0;
      last_dir   = gif.direction;
    end else begin
      stable   = (gif.direction != last_dir) ? 1 : stable + 1;
      dwell    = dwell + 1;
      last_dir = gif.direction;
      nxt      = gif.room;
      if (model_mode == 2 && gif.room != 3'b000) begin
        if (dwell >= MOVE_K) nxt = (gif.room == 3'b001) ? 3'b010 : 3'b001;
      end else if (model_mode != 3) begin
        if (gif.room == 3'b100) begin
          if (dwell >= DEN_K) nxt = gif.sword ? 3'b101 : 3'b110;
        end else if (stable >= MOVE_K) begin
          case ({gif.room, gif.direction})
            {3'b000, 2'b01}: nxt = 3'b001;
            {3'b001, 2'b10}: nxt = (model_mode == 1) ? 3'b001 : 3'b010;
            {3'b010, 2'b11}: nxt = 3'b011;
            {3'b010, 2'b01}: nxt = 3'b100;
            {3'b011, 2'b01}: nxt = 3'b010;
            default:         nxt = gif.room;
          endcase
        end
      end
      if (nxt != gif.room) begin
        if (gif.room != 3'b100 && model_mode != 2) q_dirs.push_back(gif.direction);
        q_rooms.push_back(nxt);
        if (nxt == 3'b011) gif.sword = 1'b1;
        if (nxt == 3'b101) gif.result = 1'b1;
        gif.room = nxt;
        stable   = 0;
        dwell    = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_go(input logic skip);
    go = 1'b1;
    skip_sword = skip;
    tick();
    go = 1'b0;
    skip_sword = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) tick();
    check(tag, done, 1'b1);
  endtask

  // Full sword-then-den game; also reused after a mid-game reset.
  task automatic scenario_win(input string p);
    logic [2:0] exp_rooms[6] = '{3'b001, 3'b010, 3'b011, 3'b010, 3'b100, 3'b101};
    logic [1:0] exp_dirs[5]  = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b01};
    q_rooms.delete();
    q_dirs.delete();
    model_mode = 0;
    pulse_go(1'b0);
    check({p, "_start_rise"}, gif.start, 1'b1);
    check({p, "_busy_rise"}, busy, 1'b1);
    repeat (STARTC) tick();
    check({p, "_dir_before_drive"}, gif.direction, 2'b00);
    tick();
    check({p, "_first_dir_e"}, gif.direction, 2'b01);
    wait_done({p, "_done"}, 2000);
    check({p, "_won"}, won, 1'b1);
    check({p, "_lost"}, lost, 1'b0);
    check({p, "_fault"}, fault, 1'b0);
    check({p, "_busy_fin"}, busy, 1'b0);
    check({p, "_start_fin"}, gif.start, 1'b1);
    check({p, "_moves"}, move_count, 8'd6);
    check({p, "_nrooms"}, q_rooms.size(), 6);
    check({p, "_ndirs"}, q_dirs.size(), 5);
    for (int i = 0; i < 6 && i < q_rooms.size(); i++)
      check($sformatf("%s_room%0d", p, i), q_rooms[i], exp_rooms[i]);
    for (int i = 0; i < 5 && i < q_dirs.size(); i++)
      check($sformatf("%s_dir%0d", p, i), q_dirs[i], exp_dirs[i]);
  endtask

  initial begin
    logic [2:0] lose_rooms[4] = '{3'b001, 3'b010, 3'b100, 3'b110};
    logic [1:0] lose_dirs[3]  = '{2'b01, 2'b10, 2'b01};
    int n;

    // Reset state
    do_reset();
    check("rst_start", gif.start, 1'b0);
    check("rst_dir", gif.direction, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_flags", {won, lost, fault}, 3'b000);
    check("rst_moves", move_count, 8'd0);

    // 1: win path through the stash
    scenario_win("t1");

    // 2: skip the sword, lose in the den
    do_reset();
    q_rooms.delete();
    q_dirs.delete();
    model_mode = 0;
    pulse_go(1'b1);
    wait_done("t2_done", 2000);
    check("t2_lost", lost, 1'b1);
    check("t2_won", won, 1'b0);
    check("t2_fault", fault, 1'b0);
    check("t2_moves", move_count, 8'd4);
    check("t2_nrooms", q_rooms.size(), 4);
    check("t2_ndirs", q_dirs.size(), 3);
    for (int i = 0; i < 4 && i < q_rooms.size(); i++)
      check($sformatf("t2_room%0d", i), q_rooms[i], lose_rooms[i]);
    for (int i = 0; i < 3 && i < q_dirs.size(); i++)
      check($sformatf("t2_dir%0d", i), q_dirs[i], lose_dirs[i]);

    // 3: game frozen in the tunnel -> timeout; move_count turns 1 in the DECIDE cycle
    do_reset();
    model_mode = 1;
    pulse_go(1'b0);
    for (int i = 0; i < 500 && move_count != 8'd1; i++) tick();
    check("t3_first_move", move_count, 8'd1);
    n = 0;
    while (fault !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    check("t3_fault", fault, 1'b1);
    check("t3_latency", n, HOLD + TMO + 1);
    check("t3_moves", move_count, 8'd1);
    check("t3_done", done, 1'b1);
    check("t3_won_lost", {won, lost}, 2'b00);

    // 4: one-clock reset during the second DRIVE, then a clean replay of 1
    do_reset();
    model_mode = 0;
    pulse_go(1'b0);
    for (int i = 0; i < 500 && gif.direction != 2'b10; i++) tick();
    check("t4_second_drive", gif.direction, 2'b10);
    check("t4_moves_before", move_count, 8'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_start", gif.start, 1'b0);
    check("t4_dir", gif.direction, 2'b00);
    check("t4_busy", busy, 1'b0);
    check("t4_moves", move_count, 8'd0);
    check("t4_flags", {done, won, lost, fault}, 4'b0000);
    tick();
    scenario_win("t4");

    // 5: endless oscillation -> abort at MAX_MOVES; go ignored mid-game and in FINISH
    do_reset();
    model_mode = 2;
    pulse_go(1'b0);
    for (int i = 0; i < 1000 && move_count != 8'd5; i++) tick();
    check("t5_mid_moves", move_count, 8'd5);
    pulse_go(1'b1);
    tick();
    check("t5_mid_busy", busy, 1'b1);
    check("t5_mid_moves_kept", move_count, 8'd5);
    wait_done("t5_done", 3000);
    check("t5_fault", fault, 1'b1);
    check("t5_won_lost", {won, lost}, 2'b00);
    check("t5_moves", move_count, 8'd16);
    pulse_go(1'b0);
    tick();
    tick();
    check("t5_fin_done", done, 1'b1);
    check("t5_fin_busy", busy, 1'b0);
    check("t5_fin_moves", move_count, 8'd16);
    check("t5_fin_start", gif.start, 1'b1);

    // 6: vault with result=0 at entry -> fault
    do_reset();
    model_mode = 3;
    pulse_go(1'b0);
    wait_done("t6_done", 200);
    check("t6_fault", fault, 1'b1);
    check("t6_won", won, 1'b0);
    check("t6_lost", lost, 1'b0);
    check("t6_moves", move_count, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "global timeout");
  end
endmodule
